sd_spi_cmd: RTL and testbench
=============================

Name: sd_spi_cmd

Overview:
SPI-mode SD card command engine for the board SD slot. It sequences the slot pads as SPI: SDCK is SCK, SDCMD is MOSI, SDDAT0 is MISO and SDDAT3 is chip select. It issues the power-up clock train and single 48-bit commands, then collects the R1 response byte. It drives the SD pad-side out/enable nets feeding the IO ring and is driven by a host FSM or CPU register block.

Parameters:
DIV_SLOW, 62, SCK half-period minus 1 in CK cycles for init/identification (50 MHz -> ~397 kHz)
DIV_FAST, 1, SCK half-period minus 1 in CK cycles for data-mode clocking (50 MHz -> 12.5 MHz)
NCR_MAX, 16, max response-wait bytes before timeout

Ports:
CK  input  1  system clock, 50 MHz
RSTN  input  1  asynchronous reset, active low
InitReq  input  1  start power-up sequence (80 SCK, CS high)
CmdReq  input  1  command request; accepted when CmdRdy=1
CmdRdy  output  1  engine idle, request accepted this cycle
FastClk  input  1  sampled at accept: 1=DIV_FAST, 0=DIV_SLOW
CmdIdx  input  6  command index
CmdArg  input  32  command argument
CmdCrc  input  7  CRC7 (used only without SD_CRC7_EN)
Busy  output  1  sequence in progress
RespValid  output  1  one-cycle pulse, Resp valid
RespTimeout  output  1  one-cycle pulse, no response within NCR_MAX bytes
Resp  output  8  R1 response byte
SdCkOut  output  1  SCK to SDCK pad
SdCmdOut  output  1  MOSI data to SDCMD pad
SdCmdEn  output  1  SDCMD output enable
SdDat0In  input  1  MISO from SDDAT0 pad
SdDat3Out  output  1  chip select, active low
SdDat3En  output  1  SDDAT3 output enable

Behaviour:
- Reset (RSTN low, async): state IDLE; SdCkOut=0, SdCmdOut=1, SdCmdEn=1, SdDat3Out=1, SdDat3En=1, CmdRdy=1, Busy=0, RespValid=0, RespTimeout=0, Resp=8'hFF, all counters 0. Reset mid-operation aborts immediately; no trailing clocks are issued.
- SPI mode 0: SCK idles low. MOSI updates at the SCK falling edge (first bit before the first rising edge). MISO is sampled in the CK cycle that drives SCK high.
- Divider: each SCK half-period = DIV+1 CK cycles, with DIV latched at accept. InitReq always uses DIV_SLOW.
- Accept: in IDLE only. InitReq has priority over a simultaneous CmdReq. The CmdReq accept cycle has CmdRdy=1 and CmdReq=1. CmdIdx/Arg/Crc/FastClk are captured on that edge. CmdRdy=0 and Busy=1 from the next cycle. Requests while busy are ignored.
- States:
  - IDLE.
  - INIT: CS=1, MOSI=1, exactly 80 SCK rising edges -> IDLE.
  - PRE: CS=0, 8 SCK with MOSI=1 -> SEND.
  - SEND: 48 bits MSB first = {2'b01, CmdIdx, CmdArg, Crc7, 1'b1} -> WAIT.
  - WAIT: MOSI=1, sample MISO each bit. The first sampled 0 begins the response byte -> RESP. If NCR_MAX*8 bits pass with no 0 -> TAIL with timeout flagged.
  - RESP: 7 more bits, MSB first -> TAIL.
  - TAIL: CS=1, 8 SCK with MOSI=1 -> IDLE.
- Completion: on entry to IDLE from TAIL, a one-cycle pulse of RespValid (Resp=captured byte) or RespTimeout (Resp=8'hFF). The pulse cycle has Busy=0 and CmdRdy=1. INIT completion produces no pulse.
- Bit counters saturate at their terminal counts. The WAIT byte counter does not wrap.
- SdCmdEn and SdDat3En are held 1 outside reset. SdCkOut is low in IDLE.

Optional Feature:
SD_CRC7_EN defined: CRC7 (poly x^7+x^3+1, init 0) is computed internally over the first 40 frame bits, serially during SEND, and inserted in bits 7:1. CmdCrc is ignored.
SD_CRC7_EN undefined: frame bits 7:1 = captured CmdCrc. The CRC logic is absent.

Test Plan:
1. InitReq with DIV_SLOW=62 -> exactly 80 SdCkOut rising edges; SCK period 126 CK; SdDat3Out=1 throughout; no RespValid.
2. CMD0, Arg 0, CmdCrc 7'h4A, FastClk=0; model returns 0xFF, 0xFF, 0x01 -> MOSI frame 40 00 00 00 00 95; RespValid pulse with Resp=8'h01; CS high, then 8 trailing SCK.
3. Model never drives 0 (NCR_MAX=16) -> 128 WAIT bits, then RespTimeout pulse with Resp=8'hFF; no RespValid.
4. FastClk=1, DIV_FAST=1 -> SCK period 4 CK; CmdReq held while Busy -> single frame, later requests ignored until CmdRdy.
5. RSTN asserted at bit 20 of SEND -> outputs return to reset values asynchronously; after release, a new CMD0 completes normally.
6. With SD_CRC7_EN: CMD8, Arg 32'h000001AA, CmdCrc=0 -> last frame byte 8'h87; CMD0 -> 8'h95.

Source files
------------

// File: rtl/sd_spi_cmd.sv
// Purpose: SPI-mode SD command engine; power-up clock train, 48-bit command frames, R1 response capture.
// Latency: request accepted in IDLE; Busy the next cycle; pulse after (8+48+wait+8+8) or 80 SCK periods.
// Backpressure: CmdRdy=0 while a sequence runs; InitReq/CmdReq outside IDLE are ignored, not queued.
//
// Ports:
//   CK, RSTN                        50 MHz clock, asynchronous active-low reset
//   InitReq                         80 SCK with CS high (always slow divider)
//   CmdReq/CmdRdy                   command handshake; CmdIdx/CmdArg/CmdCrc/FastClk captured at accept
//   Busy                            sequence in progress
//   RespValid/RespTimeout/Resp      one-cycle completion pulse and R1 byte (8'hFF on timeout)
//   SdCkOut/SdCmdOut/SdCmdEn        SCK and MOSI pad nets
//   SdDat0In                        MISO from the card
//   SdDat3Out/SdDat3En              chip select (active low) pad nets
// Build option: define SD_CRC7_EN to generate the frame CRC7 internally (CmdCrc then ignored).
module sd_spi_cmd #(
  parameter int DIV_SLOW = 62,
  parameter int DIV_FAST = 1,
  parameter int NCR_MAX  = 16
) (
  input  logic        CK,
  input  logic        RSTN,
  input  logic        InitReq,
  input  logic        CmdReq,
  output logic        CmdRdy,
  input  logic        FastClk,
  input  logic [5:0]  CmdIdx,
  input  logic [31:0] CmdArg,
  input  logic [6:0]  CmdCrc,
  output logic        Busy,
  output logic        RespValid,
  output logic        RespTimeout,
  output logic [7:0]  Resp,
  output logic        SdCkOut,
  output logic        SdCmdOut,
  output logic        SdCmdEn,
  input  logic        SdDat0In,
  output logic        SdDat3Out,
  output logic        SdDat3En
);

  localparam int DMAX      = (DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST;
  localparam int DW        = $clog2(DMAX + 2);
  localparam int WAIT_BITS = NCR_MAX * 8;
  localparam int BW        = $clog2(((WAIT_BITS > 80) ? WAIT_BITS : 80) + 1);
  localparam logic [BW-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_PRE, S_SEND, S_WAIT, S_RESP, S_TAIL
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   div_q, div_cnt;
  logic            sck_q;
  logic [BW-1:0]   bit_cnt;
  logic [47:0]     shreg;
  logic [7:0]      resp_q;
  logic            tout_q, rvld_q, rto_q;
  logic            tick, rise, fall, last_bit, acc_init, acc_cmd;
  logic [6:0]      crc_field;

`ifdef SD_CRC7_EN
  logic [6:0] crc_q, crc_nxt;
  logic       crc_fb;
  // Serial CRC7, poly x^7+x^3+1, fed with the bit currently on MOSI.
  assign crc_fb    = shreg[47] ^ crc_q[6];
  assign crc_nxt   = {crc_q[5:3], crc_q[2] ^ crc_fb, crc_q[1:0], crc_fb};
  assign crc_field = 7'h00;
`else
  assign crc_field = CmdCrc;
`endif

  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Phase changes happen only on an SCK falling tick, so MOSI for the next
  // phase is set up a full half-period before the card samples it.
  always_comb begin
    state_d  = state_q;
    last_bit = 1'b0;
    tick     = (state_q != S_IDLE) && (div_cnt == div_q);
    rise     = tick && !sck_q;
    fall     = tick && sck_q;
    acc_init = (state_q == S_IDLE) && InitReq;
    acc_cmd  = (state_q == S_IDLE) && !InitReq && CmdReq;
    case (state_q)
      S_IDLE: begin
        if (acc_init)     state_d = S_INIT;
        else if (acc_cmd) state_d = S_PRE;
      end
      S_INIT: begin
        last_bit = (bit_cnt == BW'(79));
        if (fall && last_bit) state_d = S_IDLE;
      end
      S_PRE: begin
        last_bit = (bit_cnt == BW'(7));
        if (fall && last_bit) state_d = S_SEND;
      end
      S_SEND: begin
        last_bit = (bit_cnt == BW'(47));
        if (fall && last_bit) state_d = S_WAIT;
      end
      S_WAIT: begin
        // resp_q stays all-ones until the first 0 is shifted in.
        last_bit = !resp_q[0] || (bit_cnt == BW'(WAIT_BITS - 1));
        if (fall && last_bit) state_d = resp_q[0] ? S_TAIL : S_RESP;
      end
      S_RESP: begin
        last_bit = (bit_cnt == BW'(6));
        if (fall && last_bit) state_d = S_TAIL;
      end
      S_TAIL: begin
        last_bit = (bit_cnt == BW'(7));
        if (fall && last_bit) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      div_q   <= '0;
      div_cnt <= '0;
      sck_q   <= 1'b0;
      bit_cnt <= '0;
      shreg   <= '0;
      resp_q  <= 8'hFF;
      tout_q  <= 1'b0;
      rvld_q  <= 1'b0;
      rto_q   <= 1'b0;
`ifdef SD_CRC7_EN
      crc_q   <= '0;
`endif
    end else begin
      rvld_q <= 1'b0;
      rto_q  <= 1'b0;
      if (acc_init || acc_cmd) begin
        div_q   <= (acc_cmd && FastClk) ? DW'(DIV_FAST) : DW'(DIV_SLOW);
        div_cnt <= '0;
        sck_q   <= 1'b0;
        bit_cnt <= '0;
        if (acc_cmd) begin
          shreg  <= {2'b01, CmdIdx, CmdArg, crc_field, 1'b1};
          resp_q <= 8'hFF;
          tout_q <= 1'b0;
`ifdef SD_CRC7_EN
          crc_q  <= '0;
`endif
        end
      end else if (state_q != S_IDLE) begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
        if (rise) begin
          sck_q <= 1'b1;
          if (state_q == S_WAIT || state_q == S_RESP)
            resp_q <= {resp_q[6:0], SdDat0In};
        end
        if (fall) begin
          sck_q <= 1'b0;
          if (last_bit)                bit_cnt <= '0;
          else if (bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + 1'b1;
          if (state_q == S_SEND) begin
`ifdef SD_CRC7_EN
            if (bit_cnt < BW'(40)) crc_q <= crc_nxt;
            // After the 40th bit the CRC slot moves to the top of the shifter.
            if (bit_cnt == BW'(39)) shreg <= {crc_nxt, shreg[39:0], 1'b1};
            else                    shreg <= {shreg[46:0], 1'b1};
`else
            shreg <= {shreg[46:0], 1'b1};
`endif
          end
          if (state_q == S_WAIT && last_bit && resp_q[0]) tout_q <= 1'b1;
          if (state_q == S_TAIL && last_bit) begin
            rvld_q <= !tout_q;
            rto_q  <= tout_q;
          end
        end
      end
    end
  end

  assign CmdRdy      = (state_q == S_IDLE);
  assign Busy        = (state_q != S_IDLE);
  assign RespValid   = rvld_q;
  assign RespTimeout = rto_q;
  assign Resp        = resp_q;
  assign SdCkOut     = sck_q;
  assign SdCmdOut    = (state_q == S_SEND) ? shreg[47] : 1'b1;
  assign SdCmdEn     = 1'b1;
  assign SdDat3Out   = !(state_q == S_PRE || state_q == S_SEND ||
                         state_q == S_WAIT || state_q == S_RESP);
  assign SdDat3En    = 1'b1;

endmodule

// File: tb/tb_sd_spi_cmd.sv
// Bench for sd_spi_cmd: a card model watches SCK edges, collects MOSI while CS is low,
// and plays back a bit stream on MISO once the 48-bit frame has been received.
// Expected R1 bytes come from scanning that stream for the first 0 within NCR_MAX bytes.
module tb_sd_spi_cmd;
  localparam int NCR_MAX = 16;
  localparam int BUDGET  = 30000;

  logic        CK, RSTN, InitReq, CmdReq, CmdRdy, FastClk;
  logic [5:0]  CmdIdx;
  logic [31:0] CmdArg;
  logic [6:0]  CmdCrc;
  logic        Busy, RespValid, RespTimeout;
  logic [7:0]  Resp;
  logic        SdCkOut, SdCmdOut, SdCmdEn, SdDat0In, SdDat3Out, SdDat3En;

  int nvec = 0;
  int nerr = 0;
  logic [47:0] last_frame;

  sd_spi_cmd dut (
    .CK(CK), .RSTN(RSTN), .InitReq(InitReq), .CmdReq(CmdReq), .CmdRdy(CmdRdy),
    .FastClk(FastClk), .CmdIdx(CmdIdx), .CmdArg(CmdArg), .CmdCrc(CmdCrc),
    .Busy(Busy), .RespValid(RespValid), .RespTimeout(RespTimeout), .Resp(Resp),
    .SdCkOut(SdCkOut), .SdCmdOut(SdCmdOut), .SdCmdEn(SdCmdEn), .SdDat0In(SdDat0In),
    .SdDat3Out(SdDat3Out), .SdDat3En(SdDat3En)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // CRC7 straight from its definition: long division by x^7+x^3+1, MSB first.
  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = 7'h00;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  task automatic chk_reset(input string tag);
    chk(tag, {SdCkOut, SdCmdOut, SdCmdEn, SdDat3Out, SdDat3En, CmdRdy, Busy,
              RespValid, RespTimeout, Resp},
             {1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF});
  endtask

  task automatic run_init();
    int   rises, cyc, last_rise, per_min, per_max;
    logic ok_cs, ok_mosi, pulse, sck_p;
    rises = 0; cyc = 0; last_rise = -1; per_min = 1000000; per_max = 0;
    ok_cs = 1'b1; ok_mosi = 1'b1; pulse = 1'b0; sck_p = 1'b0;
    @(negedge CK);
    InitReq = 1'b1; CmdReq = 1'b1; FastClk = 1'b1;   // init must win and stay slow
    @(negedge CK);
    InitReq = 1'b0; CmdReq = 1'b0;
    chk("init.busy", Busy, 1'b1);
    while (cyc < BUDGET + 300) begin
      @(negedge CK);
      cyc++;
      if (SdCkOut && !sck_p) begin
        rises++;
        if (last_rise >= 0) begin
          if (cyc - last_rise < per_min) per_min = cyc - last_rise;
          if (cyc - last_rise > per_max) per_max = cyc - last_rise;
        end
        last_rise = cyc;
      end
      sck_p   = SdCkOut;
      ok_cs   &= SdDat3Out;
      ok_mosi &= SdCmdOut;
      pulse   |= RespValid | RespTimeout;
      if (!Busy && cyc < BUDGET) cyc = BUDGET;   // then watch 300 idle cycles
    end
    chk("init.rises", rises, 80);
    chk("init.cs_high", ok_cs, 1'b1);
    chk("init.mosi_high", ok_mosi, 1'b1);
    chk("init.no_pulse", pulse, 1'b0);
    chk("init.per_min", per_min, 126);
    chk("init.per_max", per_max, 126);
    chk("init.idle", {Busy, CmdRdy, SdCkOut}, 3'b010);
  endtask

  task automatic run_cmd(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                         input logic [6:0] crc, input logic fast, input int lead,
                         input logic [15:0] pat, input bit hold, input int abort_at);
    logic        stream [0:255];
    int          z, k, cyc, n_cap, last_rise, per_min, per_max, tail_rises, exp_period, exp_bits;
    logic [7:0]  exp_resp;
    logic        exp_to, pre_ok, wait_ok, sck_p, seen_lo, done;
    logic [47:0] exp_frame, got_frame;
    logic [6:0]  exp_crc;

    for (int i = 0; i < 256; i++)
      stream[i] = (i < lead) ? 1'b1 : (i < lead + 16) ? pat[15 - (i - lead)] : 1'b1;
    z = -1;
    for (int i = 0; i < NCR_MAX * 8; i++)
      if (z < 0 && stream[i] == 1'b0) z = i;
    exp_to   = (z < 0);
    exp_resp = 8'hFF;
    if (!exp_to)
      for (int i = 0; i < 8; i++) exp_resp[7 - i] = stream[z + i];
    exp_bits = exp_to ? 56 + NCR_MAX * 8 : 56 + z + 8;
`ifdef SD_CRC7_EN
    exp_crc = crc7({2'b01, idx, arg});
`else
    exp_crc = crc;
`endif
    exp_frame  = {2'b01, idx, arg, exp_crc, 1'b1};
    exp_period = fast ? 4 : 126;

    @(negedge CK);
    CmdIdx = idx; CmdArg = arg; CmdCrc = crc; FastClk = fast; CmdReq = 1'b1; SdDat0In = 1'b1;
    chk({tag, ".rdy"}, CmdRdy, 1'b1);
    @(negedge CK);
    if (!hold) CmdReq = 1'b0;
    chk({tag, ".busy"}, {CmdRdy, Busy}, 2'b01);
    CmdIdx = ~idx; CmdArg = ~arg; CmdCrc = ~crc; FastClk = ~fast;   // must already be captured

    k = 0; cyc = 0; n_cap = 0; last_rise = -1; per_min = 1000000; per_max = 0;
    tail_rises = 0; pre_ok = 1'b1; wait_ok = 1'b1; sck_p = SdCkOut; seen_lo = 1'b0;
    done = 1'b0; got_frame = '0;
    while (!done && cyc < BUDGET) begin
      @(negedge CK);
      cyc++;
      if (SdCkOut && !sck_p) begin
        if (last_rise >= 0) begin
          if (cyc - last_rise < per_min) per_min = cyc - last_rise;
          if (cyc - last_rise > per_max) per_max = cyc - last_rise;
        end
        last_rise = cyc;
        if (!SdDat3Out) begin
          seen_lo = 1'b1;
          if (n_cap < 8)       pre_ok &= SdCmdOut;
          else if (n_cap < 56) got_frame = {got_frame[46:0], SdCmdOut};
          else                 wait_ok &= SdCmdOut;
          n_cap++;
        end else if (seen_lo) begin
          tail_rises++;
        end
      end
      // Card shifts out a new MISO bit after each falling edge once the frame is in.
      if (!SdCkOut && sck_p && !SdDat3Out && n_cap >= 56 && k < 256) begin
        SdDat0In = stream[k];
        k++;
      end
      sck_p = SdCkOut;
      if (abort_at > 0 && n_cap == abort_at) begin
        RSTN = 1'b0;
        #1;
        chk_reset({tag, ".abort"});
        @(negedge CK);
        chk_reset({tag, ".abort_hold"});
        RSTN = 1'b1; CmdReq = 1'b0; SdDat0In = 1'b1;
        return;
      end
      if (RespValid || RespTimeout) done = 1'b1;
    end
    if (hold) CmdReq = 1'b0;
    chk({tag, ".done"}, done, 1'b1);
    chk({tag, ".valid"}, RespValid, !exp_to);
    chk({tag, ".timeout"}, RespTimeout, exp_to);
    chk({tag, ".resp"}, Resp, exp_resp);
    chk({tag, ".idle"}, {Busy, CmdRdy, SdDat3Out, SdCkOut}, 4'b0110);
    chk({tag, ".pre"}, pre_ok, 1'b1);
    chk({tag, ".frame"}, got_frame, exp_frame);
    chk({tag, ".mosi_wait"}, wait_ok, 1'b1);
    chk({tag, ".cs_low_bits"}, n_cap, exp_bits);
    chk({tag, ".tail"}, tail_rises, 8);
    chk({tag, ".per_min"}, per_min, exp_period);
    chk({tag, ".per_max"}, per_max, exp_period);
    chk({tag, ".en"}, {SdCmdEn, SdDat3En}, 2'b11);
    last_frame = got_frame;
    @(negedge CK);
    chk({tag, ".after"}, {RespValid, RespTimeout, Busy, CmdRdy}, 4'b0001);
  endtask

  initial begin
    logic [31:0] r1, r2, r3;
    RSTN = 1'b0; InitReq = 1'b0; CmdReq = 1'b0; FastClk = 1'b0;
    CmdIdx = '0; CmdArg = '0; CmdCrc = '0; SdDat0In = 1'b1; last_frame = '0;
    repeat (3) @(negedge CK);
    chk_reset("reset");
    RSTN = 1'b1;
    @(negedge CK);
    chk_reset("post_reset");

    run_init();

    // CMD0 slow; card answers FF FF 01.
    run_cmd("cmd0", 6'd0, 32'h0, 7'h4A, 1'b0, 16, 16'h01FF, 1'b0, 0);
    chk("cmd0.crc_byte", last_frame[7:0], 8'h95);

    // Card never answers.
    run_cmd("tmo", 6'd17, 32'h0000_1234, 7'h11, 1'b1, 0, 16'hFFFF, 1'b0, 0);
    // Zero in the very last / one past the last wait bit.
    run_cmd("edge127", 6'd55, 32'hDEAD_BEEF, 7'h2C, 1'b1, 127, 16'h5A5A, 1'b0, 0);
    run_cmd("edge128", 6'd41, 32'h4030_0000, 7'h7F, 1'b1, 128, 16'h0000, 1'b0, 0);
    // Immediate answer 0x00.
    run_cmd("first", 6'd2, 32'hFFFF_FFFF, 7'h00, 1'b1, 0, 16'h00FF, 1'b0, 0);

    // CmdReq held high throughout: exactly one frame.
    run_cmd("hold", 6'd9, 32'hA5A5_5A5A, 7'h33, 1'b1, 5, 16'h2BFF, 1'b1, 0);

    // Reset at SEND bit 20, then a clean CMD0.
    run_cmd("abort", 6'd0, 32'h0, 7'h4A, 1'b1, 0, 16'h01FF, 1'b0, 28);
    run_cmd("cmd0b", 6'd0, 32'h0, 7'h4A, 1'b1, 3, 16'h01FF, 1'b0, 0);
    chk("cmd0b.crc_byte", last_frame[7:0], 8'h95);

`ifdef SD_CRC7_EN
    run_cmd("cmd8", 6'd8, 32'h0000_01AA, 7'h00, 1'b1, 9, 16'h01FF, 1'b0, 0);
`else
    run_cmd("cmd8", 6'd8, 32'h0000_01AA, 7'h43, 1'b1, 9, 16'h01FF, 1'b0, 0);
`endif
    chk("cmd8.crc_byte", last_frame[7:0], 8'h87);

    for (int t = 0; t < 6; t++) begin
      r1 = $urandom; r2 = $urandom; r3 = $urandom;
      run_cmd($sformatf("rnd%0d", t), r1[5:0], r2, r1[12:6], 1'b1,
              int'($urandom_range(0, 140)), r3[15:0], 1'b0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
